// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified memory port controller.
// Imported by the arbiter and the controller top.
package mem_ctrl_pkg;

  localparam int unsigned DATA_BASE  = 100;
  localparam logic [31:0] CLEAR_VAL  = 32'h2;
  localparam int unsigned STARVE_LIM = 4;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } tag_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter: data has priority until fetch has
// waited through LIM consecutive data grants.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LIM = STARVE_LIM
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int unsigned SW = $clog2(LIM + 1);

  logic [SW-1:0] streak;
  logic          starved;

  assign starved = (streak == SW'(LIM));
  assign d_gnt   = en && d_req && !(if_req && starved);
  assign if_gnt  = en && if_req && !d_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!if_req || if_gnt) begin
      streak <= '0;
    end else if (d_gnt) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port unified memory sequencer: fetch/data arbitration,
// clear bursts and routing of read responses to their requester.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter int unsigned DBASE      = DATA_BASE,
  parameter logic [31:0] CVAL       = CLEAR_VAL,
  parameter int unsigned STARVE     = STARVE_LIM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_clr,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [AW-1:0] d_len,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  state_e      state, state_n;
  tag_e        tag, tag_n;
  logic [AW-1:0] clr_addr, clr_addr_n;
  logic [AW:0]   clr_cnt, clr_cnt_n;
  logic [AW-1:0] eff_addr;
  logic [AW:0]   len;

  assign eff_addr = d_addr + AW'(DBASE);
  // a zero length still clears one word
  assign len = (d_len == '0) ? (AW+1)'(1) : {1'b0, d_len};

  mem_port_arbiter #(
    .LIM (STARVE)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state == IDLE),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  always_comb begin
    state_n    = state;
    tag_n      = NONE;
    clr_addr_n = clr_addr;
    clr_cnt_n  = clr_cnt;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    d_done     = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_gnt) begin
          mem_en   = 1'b1;
          mem_addr = eff_addr;
          if (d_clr) begin
            mem_we    = 1'b1;
            mem_wdata = CVAL;
            if (len == (AW+1)'(1)) begin
              d_done = 1'b1;
            end else begin
              state_n    = CLEAR;
              clr_addr_n = eff_addr + 1'b1;
              clr_cnt_n  = len - 1'b1;
            end
          end else if (d_we) begin
            mem_we    = 1'b1;
            mem_wdata = d_wdata;
          end else begin
            tag_n = DATA;
          end
        end else if (if_gnt) begin
          mem_en   = 1'b1;
          mem_addr = if_addr;
          tag_n    = FETCH;
        end
      end
      CLEAR: begin
        busy       = 1'b1;
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = clr_addr;
        mem_wdata  = CVAL;
        clr_addr_n = clr_addr + 1'b1;
        clr_cnt_n  = clr_cnt - 1'b1;
        if (clr_cnt == (AW+1)'(1)) begin
          d_done  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tag      <= NONE;
      clr_addr <= '0;
      clr_cnt  <= '0;
    end else begin
      state    <= state_n;
      tag      <= tag_n;
      clr_addr <= clr_addr_n;
      clr_cnt  <= clr_cnt_n;
    end
  end

  assign if_rvalid = (tag == FETCH);
  assign d_rvalid  = (tag == DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl with a behavioural
// memory and a reference model of arbitration and read data.
module tb_mem_port_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_clr;
  logic [AW-1:0] d_addr, d_len;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid, d_done;
  logic [31:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          busy;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_clr     (d_clr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_len     (d_len),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // synchronous memory with a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic idle_inputs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_clr = 0;
    d_addr = '0; d_wdata = '0; d_len = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    bd_we = 1; bd_addr = AW'(a); bd_data = v;
    @(posedge clk); #1;
    bd_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy}
        !== 8'b0 || mem_addr !== '0 || mem_wdata !== '0
        || if_rdata !== '0 || d_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got flags=%b addr=%h wdata=%h exp all 0",
        {if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy},
        mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_fetch();
    do_reset();
    preload(5, 32'h1234);
    if_req = 1; if_addr = 5;
    @(negedge clk);
    vectors++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 10'd5) begin
      miscompares++;
      $display("FAIL fetch_issue got g/d/en/we=%b addr=%0d exp 1010 addr=5",
        {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234 || d_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_resp got ivld=%b idata=%h dvld=%b exp 1 1234 0",
        if_rvalid, if_rdata, d_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'hAB;
    @(negedge clk);
    vectors++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 10'd103
        || mem_wdata !== 32'hAB) begin
      miscompares++;
      $display("FAIL data_write got g/en/we=%b addr=%0d wd=%h exp 111 103 ab",
        {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    d_we = 0;
    @(negedge clk);
    vectors++;
    if ({d_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 10'd103) begin
      miscompares++;
      $display("FAIL data_read got g/en/we=%b addr=%0d exp 110 103",
        {d_gnt, mem_en, mem_we}, mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hAB || if_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL data_resp got dvld=%b data=%h ivld=%b exp 1 ab 0",
        d_rvalid, d_rdata, if_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    do_reset();
    if_req = 1; if_addr = 0;
    d_req = 1; d_addr = 0;
    for (int i = 0; i < 10; i++) begin
      // four data grants, then fetch gets its turn
      exp = ((i % 5) == 4) ? 2'b10 : 2'b01;
      @(negedge clk);
      vectors++;
      if ({if_gnt, d_gnt} !== exp) begin
        miscompares++;
        $display("FAIL starve_cycle%0d got if/d=%b exp %b", i, {if_gnt, d_gnt}, exp);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    do_reset();
    if_req = 1; if_addr = 0;
    d_req = 1; d_clr = 1; d_addr = 10; d_len = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({if_gnt, d_gnt, mem_en, mem_we, d_done, busy}
          !== {1'b0, k == 0, 2'b11, k == 2, k != 0}
          || mem_addr !== AW'(110 + k) || mem_wdata !== 32'h2) begin
        miscompares++;
        $display("FAIL clear_w%0d got ig/dg/en/we/done/busy=%b addr=%0d wd=%h",
          k, {if_gnt, d_gnt, mem_en, mem_we, d_done, busy}, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      d_req = 0; d_clr = 0;
    end
    @(negedge clk);
    vectors++;
    if ({if_gnt, busy, d_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL clear_after got ig/busy/done=%b exp 100", {if_gnt, busy, d_done});
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_clear_wrap_reset();
    do_reset();
    for (int a = 96; a < 104; a++) preload(a, 32'hDEAD_0000 + a);
    d_req = 1; d_clr = 1; d_addr = 1020; d_len = 8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(96 + k)) begin
        miscompares++;
        $display("FAIL wrap_w%0d got en/we=%b addr=%0d exp 11 %0d",
          k, {mem_en, mem_we}, mem_addr, 96 + k);
      end
      if (k == 2) rst = 1;
      @(posedge clk); #1;
      d_req = 0; d_clr = 0;
    end
    rst = 0;
    @(negedge clk);
    vectors++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy}
        !== 8'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL wrap_reset got flags=%b addr=%h exp all 0",
        {if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy}, mem_addr);
    end
    for (int a = 96; a < 104; a++) begin
      vectors++;
      if (mem[a] !== ((a < 99) ? 32'h2 : 32'hDEAD_0000 + a)) begin
        miscompares++;
        $display("FAIL wrap_mem%0d got %h", a, mem[a]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_single();
    do_reset();
    d_req = 1; d_we = 1; d_clr = 1; d_len = 0; d_addr = 50;
    @(negedge clk);
    vectors++;
    if ({d_gnt, mem_en, mem_we, d_done, busy} !== 5'b11110
        || mem_addr !== 10'd150 || mem_wdata !== 32'h2) begin
      miscompares++;
      $display("FAIL single_clr got g/en/we/done/busy=%b addr=%0d wd=%h",
        {d_gnt, mem_en, mem_we, d_done, busy}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({mem_en, d_done, busy} !== 3'b000 || mem[150] !== 32'h2) begin
      miscompares++;
      $display("FAIL single_after got en/done/busy=%b mem=%h exp 000 2",
        {mem_en, d_done, busy}, mem[150]);
    end
    @(posedge clk); #1;
  endtask

  // random fetch/load/store traffic against a reference memory model
  task automatic test_random_traffic();
    int streak = 0;
    int pend = 0;
    logic [31:0] exp_data = '0;
    logic ir, dr, dw, fw, dwin;
    int ia, da, abs_a;
    logic [31:0] wd, v;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      v = $urandom; preload(a, v); ref_mem[a] = v;
      v = $urandom; preload(100 + a, v); ref_mem[100 + a] = v;
    end
    for (int n = 0; n < 300; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 3) != 0);
      dw = 1'($urandom_range(0, 1));
      ia = $urandom_range(0, 15);
      da = $urandom_range(0, 15);
      wd = $urandom;
      abs_a = 100 + da;
      dwin = dr && !(ir && streak == 4);
      fw = ir && !dwin;
      if_req = ir; if_addr = AW'(ia);
      d_req = dr; d_we = dw; d_addr = AW'(da); d_wdata = wd;
      @(negedge clk);
      vectors++;
      if ({if_gnt, d_gnt} !== {fw, dwin}
          || (fw && mem_addr !== AW'(ia))
          || (dwin && mem_addr !== AW'(abs_a))) begin
        miscompares++;
        $display("FAIL rnd_gnt%0d got if/d=%b addr=%0d exp %b", n,
          {if_gnt, d_gnt}, mem_addr, {fw, dwin});
      end
      vectors++;
      if (if_rvalid !== (pend == 1) || d_rvalid !== (pend == 2)
          || (pend == 1 && if_rdata !== exp_data)
          || (pend == 2 && d_rdata !== exp_data)) begin
        miscompares++;
        $display("FAIL rnd_resp%0d got iv=%b dv=%b id=%h dd=%h exp tag%0d %h", n,
          if_rvalid, d_rvalid, if_rdata, d_rdata, pend, exp_data);
      end
      pend = 0;
      if (dwin && dw) ref_mem[abs_a] = wd;
      else if (dwin) begin pend = 2; exp_data = ref_mem[abs_a]; end
      else if (fw) begin pend = 1; exp_data = ref_mem[ia]; end
      if (!ir || fw) streak = 0;
      else if (dwin) streak++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_starvation();
    test_clear();
    test_clear_wrap_reset();
    test_clear_single();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
